board_io_conditioner: RTL and testbench
=======================================

# board_io_conditioner

Parametrised board-input front end sitting between the FPGA pads and the demo system. Generates a held, synchronously released system reset from the clock generator's lock signal. Synchronises and debounces an arbitrary number of switch/button inputs, and reports a clean level plus single-cycle rise/fall pulses per channel. Optionally accumulates edges into a sticky interrupt bank.

## Interface
- `NumIn`, 8: number of conditioned input channels.
- `SyncStages`, 2: flip-flop synchroniser depth per channel; legal range 2..4.
- `DebounceCycles`, 50000: consecutive stable cycles required before a level change is accepted; must be ≥1. 1 ms at 50 MHz.
- `RstHoldCycles`, 1024: cycles `rst_out_no` is held low after `rst_sys_ni` deasserts; must be ≥1.
- `ResetLevel`, '0: `NumIn`-bit reset value of `level_o`.

- `clk_sys_i`  in  1  system clock, single domain.
- `rst_sys_ni`  in  1  asynchronous active-low reset (clock generator `locked`).
- `raw_i`  in  NumIn  asynchronous pad inputs ({SW, BTN}).
- `level_o`  out  NumIn  debounced level.
- `rise_o`  out  NumIn  one-cycle pulse on accepted 0→1.
- `fall_o`  out  NumIn  one-cycle pulse on accepted 1→0.
- `rst_out_no`  out  1  held system reset to downstream logic.
- `irq_en_i`  in  NumIn  per-channel edge enable (only with `IO_COND_IRQ_EN`).
- `irq_clear_i`  in  NumIn  write-1-to-clear pending bits (only with `IO_COND_IRQ_EN`).
- `irq_pending_o`  out  NumIn  sticky pending bits (only with `IO_COND_IRQ_EN`).
- `irq_o`  out  1  OR of `irq_pending_o` (only with `IO_COND_IRQ_EN`).

## Operation
- Reset values: `level_o`=`ResetLevel`; `rise_o`, `fall_o`, `irq_pending_o` = 0; `irq_o`=0; `rst_out_no`=0; synchroniser flops=`ResetLevel`; all counters 0.
- Reset hold: counter width `$clog2(RstHoldCycles+1)`. Counts up while `rst_out_no`=0 and reset is released. On reaching `RstHoldCycles`, `rst_out_no`←1 (registered) and the counter saturates. Asserting `rst_sys_ni` at any time drives `rst_out_no` low asynchronously and restarts the sequence.
- Per channel: `raw_i` → `SyncStages` flops → `s`. Counter width `$clog2(DebounceCycles+1)`.
  - If `s`==`level`, the counter clears.
  - If `s`≠`level`, the counter increments. When the counter would reach `DebounceCycles`: `level`←`s`, counter←0, and the matching `rise`/`fall` pulses for exactly that cycle.
  - A glitch shorter than `DebounceCycles` resets progress and produces no pulse.
  - `rise_o` and `fall_o` are never both high on the same channel.
- Channels are fully independent. Simultaneous changes on several channels each produce their own pulses in the same cycle.
- Conditioning runs regardless of `rst_out_no`. Only `rst_sys_ni` resets it.

## Timing
- `rst_out_no` rises exactly `RstHoldCycles` rising edges after the first edge with `rst_sys_ni` high.
- Raw step held stable → `level_o` changes, with the pulse, `SyncStages + DebounceCycles` cycles after the first sampling edge.
- Pulses last 1 cycle. A level cannot change again sooner than `DebounceCycles` cycles later.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `IO_COND_IRQ_EN` defined:
  - Pending bit i sets on (`rise_o[i]`|`fall_o[i]`)&`irq_en_i[i]`.
  - It clears on `irq_clear_i[i]`. Set wins over a simultaneous clear.
  - `irq_o` is registered: one cycle after pending changes.
- `IO_COND_IRQ_EN` undefined: irq ports and pending registers are absent; the remaining behaviour is identical.

## Structure
- `board_io_pkg`: default parameter constants (`DefDebounceCycles`, `DefRstHoldCycles`, `DefSyncStages`) and a `cnt_w` width helper function.
- Sub-module `io_debounce_chan`: synchroniser, counter and edge logic for one channel, generate-instantiated `NumIn` times.
- Reset hold and the irq bank live in the top module.

## Test plan
Bench parameters: `NumIn`=4, `SyncStages`=2, `DebounceCycles`=4, `RstHoldCycles`=8.
- Reset release:
  - Deassert `rst_sys_ni` → `rst_out_no` low for 8 edges, high on the 8th.
  - Reassert after 3 cycles → `rst_out_no` falls immediately, and the full 8-cycle count restarts.
- Clean step: `raw_i[0]` 0→1 held → `level_o[0]`=1 and `rise_o[0]`=1 for one cycle, 6 cycles after the sampling edge.
- Glitch: `raw_i[1]` high for 3 cycles then low → `level_o[1]` stays 0, no pulse.
- Bounce then settle: `raw_i[2]` toggles 1,0,1,0 each cycle then holds 1 → single rise, 6 cycles after the final toggle.
- Parallel channels: `raw_i`=4'b1111 from `ResetLevel` 0 → all four rise pulses coincide. A later 4'b0000 gives four simultaneous falls.
- With `IO_COND_IRQ_EN`:
  - `irq_en_i`=4'b0101 plus a rise on channels 0 and 1 → `irq_pending_o`=4'b0001, `irq_o`=1.
  - `irq_clear_i[0]` coinciding with a new edge on channel 0 → bit stays set.
  - Clear alone → `irq_o` drops the next cycle.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared defaults and a width helper for the board input conditioner.
package board_io_pkg;

    localparam int unsigned DefDebounceCycles = 50000;
    localparam int unsigned DefRstHoldCycles  = 1024;
    localparam int unsigned DefSyncStages     = 2;

    // Bits needed to hold the values 0..n; never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/io_debounce_chan.sv
// One conditioned input: synchroniser chain, stability counter and registered edge pulses.
module io_debounce_chan
    import board_io_pkg::*;
#(
    parameter int unsigned SyncStages     = DefSyncStages,
    parameter int unsigned DebounceCycles = DefDebounceCycles,
    parameter logic        ResetVal       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned            CntW    = cnt_w(DebounceCycles);
    localparam logic [CntW-1:0]        CntLast = CntW'(DebounceCycles - 1);

    logic [SyncStages-1:0] sync_q, sync_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  s;

    assign s = sync_q[SyncStages-1];

    always_comb begin
        sync_d  = {sync_q[SyncStages-2:0], raw_i};
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s != level_q) begin
            // The cycle that would complete the count accepts the new level instead.
            if (cnt_q == CntLast) begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= {SyncStages{ResetVal}};
            cnt_q   <= '0;
            level_q <= ResetVal;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/board_io_conditioner.sv
// Board input front end: held system reset plus per-channel debounce with edge pulses.
// Define IO_COND_IRQ_EN to add the sticky edge-interrupt bank and its ports.
module board_io_conditioner
    import board_io_pkg::*;
#(
    parameter int unsigned     NumIn          = 8,
    parameter int unsigned     SyncStages     = DefSyncStages,
    parameter int unsigned     DebounceCycles = DefDebounceCycles,
    parameter int unsigned     RstHoldCycles  = DefRstHoldCycles,
    parameter logic [NumIn-1:0] ResetLevel    = '0
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [NumIn-1:0] raw_i,
    output logic [NumIn-1:0] level_o,
    output logic [NumIn-1:0] rise_o,
    output logic [NumIn-1:0] fall_o,
    output logic             rst_out_no
`ifdef IO_COND_IRQ_EN
    ,
    input  logic [NumIn-1:0] irq_en_i,
    input  logic [NumIn-1:0] irq_clear_i,
    output logic [NumIn-1:0] irq_pending_o,
    output logic             irq_o
`endif
);

    localparam int unsigned     HoldW    = cnt_w(RstHoldCycles);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RstHoldCycles - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(RstHoldCycles);

    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             rst_out_q, rst_out_d;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        rst_out_d  = rst_out_q;
        if (!rst_out_q) begin
            if (hold_cnt_q == HoldLast) begin
                rst_out_d  = 1'b1;
                hold_cnt_d = HoldMax;
            end else begin
                hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            hold_cnt_q <= '0;
            rst_out_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            rst_out_q  <= rst_out_d;
        end
    end

    assign rst_out_no = rst_out_q;

    for (genvar i = 0; i < NumIn; i++) begin : g_chan
        io_debounce_chan #(
            .SyncStages     (SyncStages),
            .DebounceCycles (DebounceCycles),
            .ResetVal       (ResetLevel[i])
        ) u_chan (
            .clk_i   (clk_sys_i),
            .rst_ni  (rst_sys_ni),
            .raw_i   (raw_i[i]),
            .level_o (level_o[i]),
            .rise_o  (rise_o[i]),
            .fall_o  (fall_o[i])
        );
    end

`ifdef IO_COND_IRQ_EN
    logic [NumIn-1:0] pending_q, pending_d;
    logic             irq_q, irq_d;

    always_comb begin
        // A new edge takes priority over a clear in the same cycle.
        pending_d = (pending_q & ~irq_clear_i) | ((rise_o | fall_o) & irq_en_i);
        irq_d     = |pending_q;
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign irq_pending_o = pending_q;
    assign irq_o         = irq_q;
`endif

endmodule

// File: tb/tb_board_io_conditioner.sv
// Directed self-checking bench for board_io_conditioner (NumIn=4, DebounceCycles=4, hold 8).
module tb_board_io_conditioner;

    localparam int unsigned NumIn = 4;

    logic             clk;
    logic             rst_n;
    logic [NumIn-1:0] raw;
    logic [NumIn-1:0] level;
    logic [NumIn-1:0] rise;
    logic [NumIn-1:0] fall;
    logic             rst_out_n;
`ifdef IO_COND_IRQ_EN
    logic [NumIn-1:0] irq_en;
    logic [NumIn-1:0] irq_clear;
    logic [NumIn-1:0] irq_pending;
    logic             irq;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    board_io_conditioner #(
        .NumIn          (NumIn),
        .SyncStages     (2),
        .DebounceCycles (4),
        .RstHoldCycles  (8),
        .ResetLevel     (4'b0000)
    ) u_dut (
        .clk_sys_i     (clk),
        .rst_sys_ni    (rst_n),
        .raw_i         (raw),
        .level_o       (level),
        .rise_o        (rise),
        .fall_o        (fall),
        .rst_out_no    (rst_out_n)
`ifdef IO_COND_IRQ_EN
        ,
        .irq_en_i      (irq_en),
        .irq_clear_i   (irq_clear),
        .irq_pending_o (irq_pending),
        .irq_o         (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk(input string tag, input logic [NumIn-1:0] exp_level,
                            input logic [NumIn-1:0] exp_rise, input logic [NumIn-1:0] exp_fall);
        tick();
        check_eq({tag, ".level"}, 32'(level), 32'(exp_level));
        check_eq({tag, ".rise"}, 32'(rise), 32'(exp_rise));
        check_eq({tag, ".fall"}, 32'(fall), 32'(exp_fall));
    endtask

    initial begin
        rst_n = 1'b1;
        raw   = '0;
`ifdef IO_COND_IRQ_EN
        irq_en    = '0;
        irq_clear = '0;
`endif
        #2 rst_n = 1'b0;
        #1;
        check_eq("reset.rst_out", 32'(rst_out_n), 32'd0);
        check_eq("reset.level", 32'(level), 32'd0);
        check_eq("reset.rise", 32'(rise), 32'd0);
        check_eq("reset.fall", 32'(fall), 32'd0);
`ifdef IO_COND_IRQ_EN
        check_eq("reset.pending", 32'(irq_pending), 32'd0);
        check_eq("reset.irq", 32'(irq), 32'd0);
`endif
        repeat (2) tick();

        // Release: low for edges 1..7, high from edge 8.
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq("hold.first", 32'(rst_out_n), (k == 8) ? 32'd1 : 32'd0);
        end
        tick();
        check_eq("hold.sat", 32'(rst_out_n), 32'd1);

        // Asynchronous reassert, partial count, reassert again, full restart.
        rst_n = 1'b0;
        #1 check_eq("hold.async_drop", 32'(rst_out_n), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq("hold.partial", 32'(rst_out_n), 32'd0);
        end
        rst_n = 1'b0;
        #1 check_eq("hold.reassert", 32'(rst_out_n), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq("hold.restart", 32'(rst_out_n), (k == 8) ? 32'd1 : 32'd0);
        end

        // Clean step on channel 0: accepted on the 6th sampling edge.
        raw = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            tick_chk("step", (k >= 6) ? 4'b0001 : 4'b0000, (k == 6) ? 4'b0001 : 4'b0000, 4'b0000);
        end

        // Three-cycle glitch on channel 1 never qualifies.
        raw = 4'b0011;
        for (int k = 1; k <= 3; k++) tick_chk("glitch.hi", 4'b0001, 4'b0000, 4'b0000);
        raw = 4'b0001;
        for (int k = 1; k <= 8; k++) tick_chk("glitch.lo", 4'b0001, 4'b0000, 4'b0000);

        // Bounce on channel 2, then hold high.
        for (int i = 0; i < 4; i++) begin
            raw[2] = (i % 2 == 0);
            tick_chk("bounce", 4'b0001, 4'b0000, 4'b0000);
        end
        raw[2] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick_chk("settle", (k >= 6) ? 4'b0101 : 4'b0001, (k == 6) ? 4'b0100 : 4'b0000,
                     4'b0000);
        end

        // Fresh reset, then all channels together.
        rst_n = 1'b0;
        raw   = 4'b0000;
        #1 rst_n = 1'b1;
        check_eq("par.level_rst", 32'(level), 32'd0);
        raw = 4'b1111;
        for (int k = 1; k <= 7; k++) begin
            tick_chk("par.rise", (k >= 6) ? 4'b1111 : 4'b0000, (k == 6) ? 4'b1111 : 4'b0000,
                     4'b0000);
        end
        raw = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            tick_chk("par.fall", (k >= 6) ? 4'b0000 : 4'b1111, 4'b0000,
                     (k == 6) ? 4'b1111 : 4'b0000);
        end

`ifdef IO_COND_IRQ_EN
        irq_en = 4'b0101;
        raw    = 4'b0011;
        for (int k = 1; k <= 6; k++) begin
            tick_chk("irq.rise", (k >= 6) ? 4'b0011 : 4'b0000, (k == 6) ? 4'b0011 : 4'b0000,
                     4'b0000);
            check_eq("irq.pend_idle", 32'(irq_pending), 32'd0);
        end
        tick();
        check_eq("irq.pend_set", 32'(irq_pending), 32'b0001);
        check_eq("irq.irq_lag", 32'(irq), 32'd0);
        tick();
        check_eq("irq.irq_up", 32'(irq), 32'd1);

        raw = 4'b0010;
        for (int k = 1; k <= 6; k++) begin
            tick_chk("irq.fall", (k >= 6) ? 4'b0010 : 4'b0011, 4'b0000,
                     (k == 6) ? 4'b0001 : 4'b0000);
        end
        irq_clear = 4'b0001;
        tick();
        check_eq("irq.set_wins", 32'(irq_pending), 32'b0001);
        irq_clear = 4'b0000;
        tick();
        check_eq("irq.still_set", 32'(irq_pending), 32'b0001);
        irq_clear = 4'b0001;
        tick();
        check_eq("irq.cleared", 32'(irq_pending), 32'd0);
        check_eq("irq.irq_hold", 32'(irq), 32'd1);
        irq_clear = 4'b0000;
        tick();
        check_eq("irq.irq_drop", 32'(irq), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
